// File: rtl/mmio_arbiter.sv
// mmio_arbiter
//
// Round-robin Wishbone arbiter that lets up to N_MASTER bus masters share the
// single MMIO slave port. A grant is held for the whole CYC period so locked
// sequences and bursts reach the slave unbroken. Once the granted master drops
// CYC there is always one idle turnaround cycle before the next grant.
//
// Optional feature: define MMIO_ARB_TIMEOUT_EN to build in a watchdog that
// terminates strobes the slave never acknowledges. The arbiter then answers
// the master itself with ERR_DATA and raises the sticky err flag. Without the
// macro, transactions wait indefinitely and err/err_id are tied to 0.
//
// Ports:
//   CLK_I, RST_N_I      clock (rising edge) and asynchronous active-low reset
//   M_CYC_I/M_STB_I/M_WE_I  per-master Wishbone control, one bit per master
//   M_ADDR_I, M_DAT_I   per-master address / write data (unpacked arrays)
//   M_DAT_O             read data broadcast to all masters (qualified by ACK)
//   M_ACK_O             per-master acknowledge, only the granted bit can fire
//   S_CYC_O .. S_DAT_O  muxed request towards the MMIO slave
//   S_DAT_I, S_ACK_I    slave response
//   gnt                 one-hot current grant (0 while idle)
//   err, err_id         sticky timeout flag and index of last timed-out master

`ifndef MMIO_ADDR_WIDTH
`define MMIO_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mmio_arbiter #(
  parameter int                     N_MASTER       = 2,
  parameter int                     TIMEOUT_CYCLES = 255,
  parameter logic [`DATA_WIDTH-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                        CLK_I,
  input  logic                        RST_N_I,
  input  logic [N_MASTER-1:0]         M_CYC_I,
  input  logic [N_MASTER-1:0]         M_STB_I,
  input  logic [N_MASTER-1:0]         M_WE_I,
  input  logic [`MMIO_ADDR_WIDTH-1:0] M_ADDR_I [N_MASTER],
  input  logic [`DATA_WIDTH-1:0]      M_DAT_I  [N_MASTER],
  output logic [`DATA_WIDTH-1:0]      M_DAT_O,
  output logic [N_MASTER-1:0]         M_ACK_O,
  output logic                        S_CYC_O,
  output logic                        S_STB_O,
  output logic                        S_WE_O,
  output logic [`MMIO_ADDR_WIDTH-1:0] S_ADDR_O,
  output logic [`DATA_WIDTH-1:0]      S_DAT_O,
  input  logic [`DATA_WIDTH-1:0]      S_DAT_I,
  input  logic                        S_ACK_I,
  output logic [N_MASTER-1:0]         gnt,
  output logic                        err,
  output logic [$clog2(N_MASTER)-1:0] err_id
);

  localparam int IW = $clog2(N_MASTER);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                state_reg, state_next;
  logic [N_MASTER-1:0]   gnt_reg, gnt_next;
  logic [IW-1:0]         last_reg, last_next;

  logic [N_MASTER-1:0]   req;
  logic                  pick_found;
  logic [IW-1:0]         pick_idx;
  int                    cand;

  logic                  sel_cyc, sel_stb, sel_we;
  logic [`MMIO_ADDR_WIDTH-1:0] sel_addr;
  logic [`DATA_WIDTH-1:0]      sel_dat;
  logic [IW-1:0]         gnt_idx;

  logic                  busy;
  logic                  routed_ack;
  logic                  timeout_hit;

  assign req  = M_CYC_I & M_STB_I;
  assign busy = (state_reg == BUSY);

  // Round-robin pick: first requester starting at last+1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 1; k <= N_MASTER; k++) begin
      cand = int'(last_reg) + k;
      if (cand >= N_MASTER) cand = cand - N_MASTER;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  // Select the granted master's request; gnt_reg is one-hot or zero.
  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_dat  = '0;
    gnt_idx  = '0;
    for (int i = 0; i < N_MASTER; i++) begin
      if (gnt_reg[i]) begin
        sel_cyc  = M_CYC_I[i];
        sel_stb  = M_STB_I[i];
        sel_we   = M_WE_I[i];
        sel_addr = M_ADDR_I[i];
        sel_dat  = M_DAT_I[i];
        gnt_idx  = IW'(i);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      last_reg  <= IW'(N_MASTER - 1);
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      last_reg  <= last_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          gnt_next   = {{(N_MASTER-1){1'b0}}, 1'b1} << pick_idx;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // Only CYC ends the tenure; STB gaps keep the grant.
        if (!sel_cyc) begin
          gnt_next   = '0;
          last_next  = gnt_idx;
          state_next = IDLE;
        end
      end
      default: begin
        gnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Slave ACK is only forwarded while the granted master is strobing.
  assign routed_ack = busy & sel_stb & S_ACK_I;

  // Outputs are gated by state so an async reset clears them without a clock.
  assign S_CYC_O  = busy & sel_cyc;
  assign S_STB_O  = busy & sel_stb & ~timeout_hit;
  assign S_WE_O   = busy & sel_we;
  assign S_ADDR_O = busy ? sel_addr : '0;
  assign S_DAT_O  = busy ? sel_dat  : '0;
  assign M_ACK_O  = gnt_reg & {N_MASTER{routed_ack | timeout_hit}};
  assign M_DAT_O  = !busy      ? '0       :
                    timeout_hit ? ERR_DATA : S_DAT_I;
  assign gnt      = gnt_reg;

`ifdef MMIO_ARB_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WW-1:0] wd_reg, wd_next;
  logic          err_reg;
  logic [IW-1:0] err_id_reg;

  // Fires on the TIMEOUT_CYCLES-th unacknowledged strobe cycle.
  assign timeout_hit = busy & sel_stb & ~S_ACK_I &
                       (wd_reg == WW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_next = wd_reg;
    if (!busy || routed_ack || timeout_hit) begin
      wd_next = '0;
    end else if (sel_stb) begin
      wd_next = wd_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      wd_reg     <= '0;
      err_reg    <= 1'b0;
      err_id_reg <= '0;
    end else begin
      wd_reg <= wd_next;
      if (timeout_hit) begin
        err_reg    <= 1'b1;
        err_id_reg <= gnt_idx;
      end
    end
  end

  assign err    = err_reg;
  assign err_id = err_id_reg;
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
  assign err_id      = '0;
`endif

endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter with two masters and TIMEOUT_CYCLES=8.
// Inputs change 2 ns after a rising edge; outputs are checked 1 ns later.

`ifndef MMIO_ADDR_WIDTH
`define MMIO_ADDR_WIDTH 16
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_mmio_arbiter;

  logic                        CLK_I;
  logic                        rst_n;
  logic [1:0]                  m_cyc, m_stb, m_we;
  logic [`MMIO_ADDR_WIDTH-1:0] m_addr [2];
  logic [`DATA_WIDTH-1:0]      m_dat  [2];
  logic [`DATA_WIDTH-1:0]      m_dat_o;
  logic [1:0]                  m_ack;
  logic                        s_cyc, s_stb, s_we;
  logic [`MMIO_ADDR_WIDTH-1:0] s_addr;
  logic [`DATA_WIDTH-1:0]      s_dat_o;
  logic [`DATA_WIDTH-1:0]      s_dat;
  logic                        s_ack;
  logic [1:0]                  gnt;
  logic                        err;
  logic [0:0]                  err_id;

  int checks = 0;
  int errors = 0;

  mmio_arbiter #(
    .N_MASTER      (2),
    .TIMEOUT_CYCLES(8),
    .ERR_DATA      (32'hDEAD_BEEF)
  ) dut (
    .CLK_I   (CLK_I),
    .RST_N_I (rst_n),
    .M_CYC_I (m_cyc),
    .M_STB_I (m_stb),
    .M_WE_I  (m_we),
    .M_ADDR_I(m_addr),
    .M_DAT_I (m_dat),
    .M_DAT_O (m_dat_o),
    .M_ACK_O (m_ack),
    .S_CYC_O (s_cyc),
    .S_STB_O (s_stb),
    .S_WE_O  (s_we),
    .S_ADDR_O(s_addr),
    .S_DAT_O (s_dat_o),
    .S_DAT_I (s_dat),
    .S_ACK_I (s_ack),
    .gnt     (gnt),
    .err     (err),
    .err_id  (err_id)
  );

  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK_I);
    #2;
  endtask

  // Called right after the edge that registered a grant to master idx.
  // Slave acks at once, master then drops CYC, bench waits for idle.
  task automatic serve(input int idx, input logic [31:0] rdata, input string tag);
    chk({tag, " gnt"}, {30'd0, gnt}, 32'(1 << idx));
    s_ack = 1'b1;
    s_dat = rdata;
    #1;
    chk({tag, " ack"}, {30'd0, m_ack}, 32'(1 << idx));
    chk({tag, " rdata"}, m_dat_o, rdata);
    tick;
    s_ack      = 1'b0;
    m_cyc[idx] = 1'b0;
    m_stb[idx] = 1'b0;
    m_we[idx]  = 1'b0;
    #1;
    chk({tag, " cyc drop"}, {31'd0, s_cyc}, 32'd0);
    tick;
    chk({tag, " idle"}, {30'd0, gnt}, 32'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    m_cyc  = '0;
    m_stb  = '0;
    m_we   = '0;
    m_addr[0] = '0; m_addr[1] = '0;
    m_dat[0]  = '0; m_dat[1]  = '0;
    s_dat  = 32'hFFFF_0000;
    s_ack  = 1'b0;

    // Reset state
    #12;
    chk("rst gnt", {30'd0, gnt}, 32'd0);
    chk("rst s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("rst s_stb", {31'd0, s_stb}, 32'd0);
    chk("rst m_ack", {30'd0, m_ack}, 32'd0);
    chk("rst m_dat_o", m_dat_o, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    chk("rst err_id", {31'd0, err_id}, 32'd0);
    rst_n = 1'b1;
    tick;

    // Single master 0 read
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 16'h0010;
    #1;
    chk("t1 no gnt before edge", {30'd0, gnt}, 32'd0);
    tick;
    chk("t1 gnt", {30'd0, gnt}, 32'd1);
    chk("t1 s_stb", {31'd0, s_stb}, 32'd1);
    chk("t1 s_addr", {16'd0, s_addr}, 32'h0010);
    chk("t1 s_we", {31'd0, s_we}, 32'd0);
    chk("t1 no ack yet", {30'd0, m_ack}, 32'd0);
    tick;
    s_ack = 1'b1; s_dat = 32'h1234_5678;
    #1;
    chk("t1 ack", {30'd0, m_ack}, 32'd1);
    chk("t1 rdata", m_dat_o, 32'h1234_5678);
    tick;
    s_ack = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1;
    chk("t1 s_cyc drop", {31'd0, s_cyc}, 32'd0);
    chk("t1 ack gone", {30'd0, m_ack}, 32'd0);
    tick;
    chk("t1 idle", {30'd0, gnt}, 32'd0);

    // Async reset mid-transaction (master 1 write in flight)
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_addr[1] = 16'h0020; m_dat[1] = 32'hAAAA_5555;
    tick;
    chk("t5 gnt", {30'd0, gnt}, 32'd2);
    chk("t5 s_cyc", {31'd0, s_cyc}, 32'd1);
    chk("t5 s_we", {31'd0, s_we}, 32'd1);
    chk("t5 s_dat", s_dat_o, 32'hAAAA_5555);
    s_ack = 1'b1; s_dat = 32'h0BAD_F00D;
    #1;
    chk("t5 ack before rst", {30'd0, m_ack}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t5 rst gnt", {30'd0, gnt}, 32'd0);
    chk("t5 rst s_cyc", {31'd0, s_cyc}, 32'd0);
    chk("t5 rst m_ack", {30'd0, m_ack}, 32'd0);
    chk("t5 rst m_dat_o", m_dat_o, 32'd0);
    #2;
    rst_n = 1'b1;
    s_ack = 1'b0;

    // Both masters request from reset; order must alternate 0,1,0,1
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 16'h0030;
    tick;
    serve(0, 32'h0000_0001, "t2a");
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick;
    chk("t2b s_we", {31'd0, s_we}, 32'd1);
    chk("t2b s_dat", s_dat_o, 32'hAAAA_5555);
    serve(1, 32'h0000_0002, "t2b");
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick;
    serve(0, 32'h0000_0003, "t2c");
    tick;
    serve(1, 32'h0000_0004, "t2d");

    // Master 1 burst of 4 writes while master 0 waits
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b1;
    m_addr[1] = 16'h0040; m_dat[1] = 32'h0000_0100;
    tick;
    chk("t3 gnt", {30'd0, gnt}, 32'd2);
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_addr[0] = 16'h0060;
    for (int w = 0; w < 4; w++) begin
      m_addr[1] = 16'(16'h0040 + w);
      m_dat[1]  = 32'h0000_0100 + 32'(w);
      s_ack = 1'b1;
      #1;
      chk($sformatf("t3 w%0d gnt", w), {30'd0, gnt}, 32'd2);
      chk($sformatf("t3 w%0d s_stb", w), {31'd0, s_stb}, 32'd1);
      chk($sformatf("t3 w%0d s_addr", w), {16'd0, s_addr}, 32'h0040 + 32'(w));
      chk($sformatf("t3 w%0d s_dat", w), s_dat_o, 32'h0000_0100 + 32'(w));
      chk($sformatf("t3 w%0d ack", w), {30'd0, m_ack}, 32'd2);
      tick;
    end
    // STB gap with CYC held: stray slave ACK ignored, grant kept
    m_stb[1] = 1'b0;
    #1;
    chk("t3 gap ack ignored", {30'd0, m_ack}, 32'd0);
    chk("t3 gap s_stb", {31'd0, s_stb}, 32'd0);
    chk("t3 gap s_cyc", {31'd0, s_cyc}, 32'd1);
    tick;
    s_ack = 1'b0;
    chk("t3 grant kept", {30'd0, gnt}, 32'd2);
    m_cyc[1] = 1'b0; m_we[1] = 1'b0;
    tick;
    chk("t3 idle", {30'd0, gnt}, 32'd0);
    tick;
    serve(0, 32'h0000_0005, "t3m0");

    // Slave never acks master 1 read
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_we[1] = 1'b0; m_addr[1] = 16'h0050;
    s_dat = 32'h5A5A_5A5A;
    tick;
    chk("t4 gnt", {30'd0, gnt}, 32'd2);
    for (int n = 1; n <= 7; n++) begin
      #1;
      chk($sformatf("t4 strobe%0d no ack", n), {30'd0, m_ack}, 32'd0);
      chk($sformatf("t4 strobe%0d s_stb", n), {31'd0, s_stb}, 32'd1);
      tick;
    end
    #1;
`ifdef MMIO_ARB_TIMEOUT_EN
    chk("t4 timeout ack", {30'd0, m_ack}, 32'd2);
    chk("t4 timeout data", m_dat_o, 32'hDEAD_BEEF);
    chk("t4 timeout s_stb", {31'd0, s_stb}, 32'd0);
    tick;
    chk("t4 err", {31'd0, err}, 32'd1);
    chk("t4 err_id", {31'd0, err_id}, 32'd1);
    chk("t4 grant held", {30'd0, gnt}, 32'd2);
`else
    chk("t4 strobe8 no ack", {30'd0, m_ack}, 32'd0);
    chk("t4 strobe8 s_stb", {31'd0, s_stb}, 32'd1);
    tick;
    chk("t4 err", {31'd0, err}, 32'd0);
    chk("t4 still no ack", {30'd0, m_ack}, 32'd0);
    chk("t4 grant held", {30'd0, gnt}, 32'd2);
`endif
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick;
    chk("t4 idle", {30'd0, gnt}, 32'd0);
`ifdef MMIO_ARB_TIMEOUT_EN
    chk("t4 err sticky", {31'd0, err}, 32'd1);
`else
    chk("t4 err tied", {31'd0, err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
